// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FWFT FIFO and its read-side masters.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   FIFO_DATA_WIDTH  default word width shared by the FIFO and its readers
//   burst_state_t    burst reader FSM states
//   burst_len_legal  length check used when a burst is requested
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } burst_state_t;

  // A burst must move at least one word and no more than the reader can count.
  function automatic logic burst_len_legal(input int unsigned len,
                                           input int unsigned max_len);
    return (len != 0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/fifo_burst_reader.sv
// Pops exactly burst_len words from an FWFT FIFO onto a registered valid/ready stream.
// Latency: FIFO head to m_valid is 1 cycle; 1 word/cycle while FIFO non-empty and m_ready high.
// Backpressure: a stalled word holds m_data/m_last; no pop while m_valid && !m_ready.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start, burst_len             burst request (sampled in IDLE only)
//   abort                        stop popping, finish the in-flight word, return to IDLE
//   fifo_empty, fifo_data        FIFO status and combinational head word
//   fifo_cs, fifo_rd_en          FIFO select / pop strobe (same cycle as the pop)
//   m_valid, m_data, m_last      output stream, m_ready downstream accept
//   busy, done, aborted          status: non-IDLE, completion pulse, completion-was-abort
//   err_len                      pulse when start carries an illegal length
//   words_left                   words still to be popped in the current burst
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter  int MAX_BURST  = 256,
  localparam int LEN_W      = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      burst_len,
  input  logic                  abort,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  err_len,
  output logic [LEN_W-1:0]      words_left
);

  burst_state_t state;
  logic         abort_pend;  // DRAIN was entered because of an abort
  logic         accept;
  logic         pop;
  logic         len_ok;

  assign accept = m_valid && m_ready;
  assign len_ok = burst_len_legal(32'(burst_len), 32'(MAX_BURST));

  // The output register may refill in the same cycle its word is accepted,
  // which is what gives back-to-back throughput.
  always_comb begin
    pop = (state == STREAM) && !fifo_empty && !abort &&
          (!m_valid || m_ready) && (words_left != '0);
  end

  assign fifo_rd_en = pop;
  assign fifo_cs    = pop;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      abort_pend <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      err_len    <= 1'b0;
      words_left <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      err_len <= 1'b0;

      // Output register: load on pop, otherwise empty on handshake, else hold.
      if (pop) begin
        m_data     <= fifo_data;
        m_valid    <= 1'b1;
        m_last     <= (words_left == LEN_W'(1));
        words_left <= words_left - LEN_W'(1);
      end else if (accept) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      case (state)
        IDLE: begin
          abort_pend <= 1'b0;
          if (start) begin
            if (len_ok) begin
              words_left <= burst_len;
              state      <= STREAM;
            end else begin
              err_len <= 1'b1;
            end
          end
        end

        STREAM: begin
          if (pop && (words_left == LEN_W'(1))) begin
            state <= DRAIN;
          end else if (abort) begin
            // abort blocks pop, so only the already-registered word can remain.
            if (m_valid && !m_ready) begin
              abort_pend <= 1'b1;
              state      <= DRAIN;
            end else begin
              done    <= 1'b1;
              aborted <= 1'b1;
              state   <= IDLE;
            end
          end
        end

        DRAIN: begin
          // External abort is irrelevant here: nothing is left to pop.
          if (accept) begin
            done       <= 1'b1;
            aborted    <= abort_pend;
            abort_pend <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
